// File: rtl/mux4_rr_sequencer.sv
// mux4_rr_sequencer: round-robin select sequencer driving a 4->1 mux select with a fixed dwell window
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst_n - asynchronous active-low reset
//   en    - enable; low pauses arbitration and the dwell countdown
//   req   - per-input request; req[i] asks for sel=i and is held until ack[i]
//   sel   - registered mux select
//   valid - registered; high while sel is stable on a granted input
//   ack   - registered one-hot, one-cycle pulse ending a grant
//   busy  - high whenever the sequencer is not idle
module mux4_rr_sequencer #(
    parameter int HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] req,
    output logic [1:0] sel,
    output logic       valid,
    output logic [3:0] ack,
    output logic       busy
);
    localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic [1:0] {IDLE, DWELL, RELEASE} state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       ptr, ptr_n;
    logic [1:0]       sel_n;
    logic             valid_n;
    logic [3:0]       ack_n;
    logic [1:0]       g;
    logic [1:0]       c;

    // Walk from the lowest priority candidate (ptr itself) up to ptr+1 so
    // that the last hit, i.e. the nearest index after ptr, wins.
    always_comb begin
        g = ptr;
        c = ptr;
        for (int i = 4; i >= 1; i--) begin
            c = ptr + 2'(i);
            if (req[c]) g = c;
        end
    end

    // While a grant is active sel already holds the winner, so the release
    // decision uses sel rather than re-arbitrating on a changing req.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        ptr_n   = ptr;
        sel_n   = sel;
        valid_n = valid;
        ack_n   = 4'b0000;
        case (state)
            IDLE: begin
                valid_n = 1'b0;
                if (en && |req) begin
                    sel_n   = g;
                    valid_n = 1'b1;
                    cnt_n   = CNT_W'(HOLD - 1);
                    state_n = DWELL;
                end
            end
            DWELL: begin
                if (en) begin
                    if (cnt != '0) begin
                        cnt_n = cnt - 1'b1;
                    end else begin
                        valid_n = 1'b0;
                        ack_n   = 4'(4'b0001 << sel);
                        ptr_n   = sel;
                        state_n = RELEASE;
                    end
                end
            end
            RELEASE: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
            default: begin
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            ptr   <= 2'b11;
            sel   <= 2'b00;
            valid <= 1'b0;
            ack   <= 4'b0000;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            ptr   <= ptr_n;
            sel   <= sel_n;
            valid <= valid_n;
            ack   <= ack_n;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux4_rr_sequencer.sv
// tb_mux4_rr_sequencer: scoreboard bench for mux4_rr_sequencer against a grant-level reference model
module tb_mux4_rr_sequencer;
    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [1:0] sel;
    logic       valid;
    logic [3:0] ack;
    logic       busy;

    mux4_rr_sequencer #(.HOLD(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .sel(sel), .valid(valid), .ack(ack), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       valid;
        logic [1:0] sel;
        logic [3:0] ack;
    } exp_t;

    typedef struct packed {
        logic [1:0]  idx;
        logic [15:0] vc;
    } grant_t;

    exp_t   cyc_q[$];
    grant_t grant_q[$];
    int     checks = 0;
    int     fails = 0;

    // Reference model: phase 0 = no grant, 1 = grant window open, 2 = ack cycle.
    int m_phase = 0;
    int m_ptr = 3;
    int m_g = 0;
    int m_sel = 0;
    int m_left = 0;
    int m_vc = 0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, x, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr = 3;
        m_g = 0;
        m_sel = 0;
        m_left = 0;
        m_vc = 0;
    endtask

    // Predicts the outcome of the upcoming rising edge from the inputs now applied.
    task automatic step();
        exp_t e;
        bit   found;
        if (m_phase == 2) begin
            m_phase = 0;
        end else if (m_phase == 1) begin
            m_vc++;
            if (en) m_left--;
            if (m_left == 0) begin
                m_phase = 2;
                m_ptr = m_g;
                grant_q.push_back('{idx: 2'(m_g), vc: 16'(m_vc)});
            end
        end else if (en && req != 4'b0000) begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    m_g = (m_ptr + k) % 4;
                    found = 1;
                end
            end
            m_phase = 1;
            m_left = HOLD;
            m_vc = 0;
            m_sel = m_g;
        end
        e.busy  = (m_phase != 0);
        e.valid = (m_phase == 1);
        e.sel   = 2'(m_sel);
        e.ack   = (m_phase == 2) ? 4'(4'b0001 << m_g) : 4'b0000;
        cyc_q.push_back(e);
    endtask

    // One clock of stimulus: requesters OR in new bits, drop their bit while
    // being acknowledged, and optionally drop the granted bit mid-window.
    task automatic cyc(input logic e_v, input logic [3:0] add, input bit drop = 0);
        logic [3:0] r;
        @(negedge clk);
        rst_n = 1'b1;
        en = e_v;
        r = req | add;
        if (m_phase == 2 || (m_phase == 1 && drop)) r[m_g] = 1'b0;
        req = r;
        step();
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (req != 4'b0000 || m_phase != 0); n++) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {busy, valid, sel, ack}, 32'h0);
        req = 4'b0000;
        cyc_q.delete();
        grant_q.delete();
        model_reset();
        repeat (2) @(posedge clk);
    endtask

    initial begin
        exp_t   e;
        grant_t gt;
        int     vcnt;
        vcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                vcnt = 0;
                continue;
            end
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                chk("busy", 32'(busy), 32'(e.busy));
                chk("valid", 32'(valid), 32'(e.valid));
                chk("sel", 32'(sel), 32'(e.sel));
                chk("ack", 32'(ack), 32'(e.ack));
            end
            chk("valid_ack_excl", 32'(valid && ack != 4'b0000), 32'h0);
            if (valid) vcnt++;
            if (ack != 4'b0000) begin
                if (grant_q.size() == 0) begin
                    chk("grant_unexpected", 32'(ack), 32'h0);
                end else begin
                    gt = grant_q.pop_front();
                    chk("grant_idx", 32'(ack), 32'(4'b0001 << gt.idx));
                    chk("grant_len", 32'(vcnt), 32'(gt.vc));
                end
                vcnt = 0;
            end
        end
    end

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {busy, valid, sel, ack}, 32'h0);
        repeat (10) cyc(1'b1, 4'b0000);
        cyc(1'b1, 4'b0100);
        repeat (6) cyc(1'b1, 4'b0000);
        repeat (20) cyc(1'b1, 4'b1111);
        drain();
        cyc(1'b1, 4'b0100);
        drain();
        cyc(1'b1, 4'b0011);
        drain();
        cyc(1'b1, 4'b0001);
        cyc(1'b1, 4'b0000);
        repeat (5) cyc(1'b0, 4'b0000);
        drain();
        cyc(1'b1, 4'b0010);
        cyc(1'b1, 4'b0000);
        do_reset();
        cyc(1'b1, 4'b1000);
        drain();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) do_reset();
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                $urandom_range(0, 19) == 0);
        end
        drain();
        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(cyc_q.size() + grant_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mux4_rr_sequencer.md
Name: mux4_rr_sequencer

Overview:
Round-robin select sequencer that sits directly upstream of the 4->1 multiplexer and drives its 2-bit select. It arbitrates among four requesters and holds each winner's select stable for a programmable dwell time. It frames the window with a valid flag and ends it with a one-cycle per-requester acknowledge. Downstream logic samples the mux output only while valid is high.

Parameters:
HOLD, 4, dwell length in clock cycles that sel stays on one winner with valid high; legal range 1..255.
CNT_W, derived as max(1, $clog2(HOLD)), width of the dwell down-counter; not overridden by users.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  sequencer enable; low pauses arbitration and dwell
req  input  4  request per mux data input; req[i] asks for sel=i, held until ack[i]
sel  output  2  select to the mux4, registered
valid  output  1  high while sel is stable on a granted input, registered
ack  output  4  one-hot, one-cycle pulse ending a grant, registered
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, sel=2'b00, valid=0, ack=4'b0000, cnt=0, ptr=2'b11. Reset is effective immediately, including mid-dwell; no ack is issued for the interrupted grant.
- ptr holds the last granted index. The search order is ptr+1, ptr+2, ptr+3, ptr (mod 4). The first set req bit in that order wins (g).
- FSM states: IDLE, DWELL, RELEASE.
- IDLE:
  - If en=1 and |req=1 at a rising edge: sel<=g, valid<=1, cnt<=HOLD-1, go to DWELL.
  - Otherwise stay in IDLE; valid=0, ack=0, sel holds its last value.
  - Latency: a request sampled at edge k gives sel/valid at edge k+1.
- DWELL:
  - valid=1 and sel stable.
  - If en=1: when cnt!=0, cnt<=cnt-1. When cnt==0: valid<=0, ack[g]<=1, ptr<=g, go to RELEASE.
  - If en=0: cnt, sel and valid freeze; state stays DWELL.
  - valid is therefore high for exactly HOLD enabled cycles.
- RELEASE:
  - Lasts exactly one cycle, independent of en; ack[g]=1, valid=0.
  - Next state is IDLE, with ack<=0.
  - The requester must deassert req[g] at the edge that ends the RELEASE cycle.
- Grants are never aborted. If req[g] drops during DWELL, the dwell completes and ack[g] is still issued.
- Changes on req lines other than g during DWELL/RELEASE have no effect until the next IDLE evaluation.
- Throughput: one grant per HOLD+2 cycles under continuous requests (IDLE, HOLD x DWELL, RELEASE).
- ack is at most one-hot. valid and ack are never high in the same cycle.
- busy is combinational from state: busy=(state!=IDLE).
- Wrap-around: ptr=3 searches from index 0. A single persistent requester is re-granted every HOLD+2 cycles.

Test Plan:
1. Reset then idle: rst_n low 3 cycles then high, req=0000, en=1 for 10 cycles -> sel=00, valid=0, ack=0000, busy=0 throughout.
2. Single grant, HOLD=4: req=0100 sampled at edge k -> sel=10 and valid=1 for edges k+1..k+4; ack=0100 for one cycle at k+5; IDLE at k+6.
3. Round-robin fairness, HOLD=1: req=1111 held (each bit re-asserted after its ack) -> grant order 0,1,2,3,0, with a new grant every 3 cycles.
4. Skip and wrap: ptr=2 after a grant to 2, then req=0011 -> next grant 0 (wrap past 3), following grant 1.
5. Pause, HOLD=3: en dropped for 5 cycles after the first DWELL cycle -> valid stays 1 and sel frozen; total valid-high cycles = 3+5; exactly one ack pulse.
6. Reset mid-dwell: rst_n pulsed low asynchronously during DWELL -> valid=0 and sel=00 immediately, no ack pulse; after release, req=1000 gives grant 3 first (ptr reset to 3, search starts at 0, only 3 pending).
